hsk_uart_tx: RTL and testbench

- Housekeeping serial transmitter toward the TURFIO: 8N1 UART at 500 kbps, fed from a byte stream through a small FIFO.
- Drives the hsk_tx line and produces the "transmit active" strobe consumed by surf_id_ctrl's hsk_tx_i input.
- Consumes surf_id_ctrl's watchdog_trigger_o and watchdog_null_o. It aborts traffic and forces the null/break condition on the line when the watchdog fires.

---
 rtl/hsk_pkg.sv | 15 +
 rtl/hsk_byte_fifo.sv | 62 ++++++
 rtl/hsk_uart_tx.sv | 214 +++++++++++++++++++++
 tb/tb_hsk_uart_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsk_pkg.sv
// Shared types and constants for the housekeeping UART transmitter.
package hsk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NULL
  } hsk_tx_state_t;

  localparam int HSK_BITS_PER_FRAME       = 10;
  localparam int HSK_DEFAULT_CLKS_PER_BIT = 400;

endpackage

// File: rtl/hsk_byte_fifo.sv
// First-word fall-through byte FIFO with synchronous flush and occupancy count.
module hsk_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hsk_uart_tx.sv
// 8N1 housekeeping UART transmitter with watchdog abort/null handling.
// Define HSK_UART_TX_STATS_EN to add the tx_bytes_o / drop_bytes_o counters.
module hsk_uart_tx
  import hsk_pkg::*;
#(
  parameter int CLKS_PER_BIT = HSK_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [7:0]                  s_tdata_i,
  input  logic                        s_tvalid_i,
  output logic                        s_tready_o,
  input  logic                        watchdog_trigger_i,
  input  logic                        watchdog_null_i,
  output logic                        hsk_tx_o,
  output logic                        hsk_tx_active_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
`ifdef HSK_UART_TX_STATS_EN
  ,
  output logic [15:0]                 tx_bytes_o,
  output logic [15:0]                 drop_bytes_o
`endif
);

  localparam int            CW           = $clog2(FIFO_DEPTH) + 1;
  localparam int            TW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);

  hsk_tx_state_t r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [2:0]    r_bit_cnt, w_bit_cnt_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_tx, w_tx_next;
  logic          r_active, w_active_next;
  logic          r_ready;
  logic          r_null_d;

  logic          w_null_rise;
  logic          w_flush;
  logic          w_handshake;
  logic          w_push;
  logic          w_discard;
  logic          w_pop;
  logic [7:0]    w_fifo_data;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [CW-1:0] w_count_next;

  assign w_null_rise = watchdog_null_i & ~r_null_d;
  assign w_flush     = w_null_rise | watchdog_trigger_i;
  assign w_handshake = s_tvalid_i & r_ready;
  assign w_push      = w_handshake & ~w_flush;
  assign w_discard   = w_handshake & w_flush;

  hsk_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n_i),
    .i_push  (w_push),
    .i_data  (s_tdata_i),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Ready is registered, so it must be derived from next cycle's occupancy.
  always_comb begin
    w_count_next = w_fifo_count;
    if (w_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = w_fifo_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = w_fifo_count - CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_ready   <= 1'b0;
      r_null_d  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_active  <= w_active_next;
      r_ready   <= watchdog_trigger_i | (w_count_next != CW'(FIFO_DEPTH));
      r_null_d  <= watchdog_null_i;
    end
  end

  // Line level is computed one state ahead so hsk_tx_o is a plain flop output.
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_active_next  = r_active;
    w_pop          = 1'b0;
    if (w_null_rise) begin
      w_state_next  = NULL;
      w_tx_next     = 1'b0;
      w_active_next = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_fifo_empty && !watchdog_trigger_i) begin
            w_pop         = 1'b1;
            w_shift_next  = w_fifo_data;
            w_timer_next  = TIMER_RELOAD;
            w_state_next  = START;
            w_tx_next     = 1'b0;
            w_active_next = 1'b1;
          end
        end
        START: begin
          if (r_timer == '0) begin
            w_state_next   = DATA;
            w_timer_next   = TIMER_RELOAD;
            w_bit_cnt_next = '0;
            w_tx_next      = r_shift[0];
          end else begin
            w_timer_next = r_timer - TW'(1);
          end
        end
        DATA: begin
          if (r_timer == '0) begin
            w_timer_next = TIMER_RELOAD;
            if (r_bit_cnt == 3'd7) begin
              w_state_next = STOP;
              w_tx_next    = 1'b1;
            end else begin
              w_bit_cnt_next = r_bit_cnt + 3'd1;
              w_shift_next   = {1'b0, r_shift[7:1]};
              w_tx_next      = r_shift[1];
            end
          end else begin
            w_timer_next = r_timer - TW'(1);
          end
        end
        STOP: begin
          if (r_timer == '0) begin
            if (!w_fifo_empty && !watchdog_trigger_i) begin
              w_pop        = 1'b1;
              w_shift_next = w_fifo_data;
              w_timer_next = TIMER_RELOAD;
              w_state_next = START;
              w_tx_next    = 1'b0;
            end else begin
              w_state_next  = IDLE;
              w_active_next = 1'b0;
            end
          end else begin
            w_timer_next = r_timer - TW'(1);
          end
        end
        NULL: begin
          if (!watchdog_null_i) begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
          end
        end
        default: begin
          w_state_next  = IDLE;
          w_tx_next     = 1'b1;
          w_active_next = 1'b0;
        end
      endcase
    end
  end

  assign s_tready_o      = r_ready;
  assign hsk_tx_o        = r_tx;
  assign hsk_tx_active_o = r_active;
  assign fifo_count_o    = w_fifo_count;

`ifdef HSK_UART_TX_STATS_EN
  logic [15:0] r_tx_bytes;
  logic [15:0] r_drop_bytes;

  // A flush drops the whole current occupancy in a single cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_tx_bytes   <= '0;
      r_drop_bytes <= '0;
    end else begin
      if (r_state == STOP && r_timer == '0 && !w_null_rise) begin
        r_tx_bytes <= r_tx_bytes + 16'd1;
      end
      r_drop_bytes <= r_drop_bytes
                    + (w_flush ? 16'(w_fifo_count) : 16'd0)
                    + 16'(w_discard);
    end
  end

  assign tx_bytes_o   = r_tx_bytes;
  assign drop_bytes_o = r_drop_bytes;
`endif

endmodule

// File: tb/tb_hsk_uart_tx.sv
// Directed self-checking bench for hsk_uart_tx at 4 clocks per bit, 16-deep FIFO.
module tb_hsk_uart_tx;
  import hsk_pkg::*;

  localparam int CPB          = 4;
  localparam int DEPTH        = 16;
  localparam int CW           = $clog2(DEPTH) + 1;
  localparam int FRAME_CYCLES = HSK_BITS_PER_FRAME * CPB;

  logic          clk = 1'b0;
  logic          rstN;
  logic [7:0]    sTdata;
  logic          sTvalid;
  logic          sTready;
  logic          wdTrigger;
  logic          wdNull;
  logic          hskTx;
  logic          hskActive;
  logic [CW-1:0] fifoCount;
`ifdef HSK_UART_TX_STATS_EN
  logic [15:0]   txBytes;
  logic [15:0]   dropBytes;
`endif

  int checks = 0;
  int errors = 0;

  logic       monEn = 1'b0;
  logic [7:0] rxQ[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  hsk_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wb_clk_i           (clk),
    .wb_rst_n_i         (rstN),
    .s_tdata_i          (sTdata),
    .s_tvalid_i         (sTvalid),
    .s_tready_o         (sTready),
    .watchdog_trigger_i (wdTrigger),
    .watchdog_null_i    (wdNull),
    .hsk_tx_o           (hskTx),
    .hsk_tx_active_o    (hskActive),
    .fifo_count_o       (fifoCount)
`ifdef HSK_UART_TX_STATS_EN
    ,
    .tx_bytes_o         (txBytes),
    .drop_bytes_o       (dropBytes)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one byte on the stream port until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [7:0] data);
    int guard;
    guard   = 0;
    sTdata  = data;
    sTvalid = 1'b1;
    while (!sTready && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("push_ready", 32'(sTready), 1);
    tick();
    sTvalid = 1'b0;
  endtask

  // Independent 8N1 receiver: samples mid-bit, LSB first, checks the stop bit.
  initial begin : rxMonitor
    int         rxCnt;
    logic       rxBusy;
    logic [7:0] rxByte;
    rxCnt  = 0;
    rxBusy = 1'b0;
    rxByte = '0;
    forever begin
      @(negedge clk);
      if (!monEn || !rstN) begin
        rxBusy = 1'b0;
      end else if (!rxBusy) begin
        if (hskTx == 1'b0) begin
          rxBusy = 1'b1;
          rxCnt  = 0;
        end
      end else begin
        rxCnt++;
        if ((rxCnt % CPB) == CPB / 2 && rxCnt / CPB >= 1 && rxCnt / CPB <= 8) begin
          rxByte = {hskTx, rxByte[7:1]};
        end
        if (rxCnt == 9 * CPB + CPB / 2) begin
          checkOutput("rx_stop_bit", 32'(hskTx), 1);
          rxQ.push_back(rxByte);
          rxBusy = 1'b0;
        end
      end
    end
  end

  initial begin : globalTimeout
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : mainTest
    int   sent;
    int   peak;
    int   guard;
    int   activeCycles;
    logic hs;
    logic sawNotReady;
    logic sawActivity;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h00, 10'b1000000000};
    vecs[4] = '{8'h81, 10'b1100000010};

    rstN      = 1'b0;
    sTdata    = '0;
    sTvalid   = 1'b0;
    wdTrigger = 1'b0;
    wdNull    = 1'b0;

    // Reset values
    #22;
    checkOutput("rst_tx", 32'(hskTx), 1);
    checkOutput("rst_active", 32'(hskActive), 0);
    checkOutput("rst_ready", 32'(sTready), 0);
    checkOutput("rst_count", 32'(fifoCount), 0);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    tick();
    checkOutput("ready_after_rst", 32'(sTready), 1);

    // Single frames: start latency, bit pattern, active width
    for (int v = 0; v < 5; v++) begin
      sTdata  = vecs[v].data;
      sTvalid = 1'b1;
      checkOutput($sformatf("v%0d_ready", v), 32'(sTready), 1);
      tick();
      sTvalid = 1'b0;
      checkOutput($sformatf("v%0d_tx_idle_c1", v), 32'(hskTx), 1);
      checkOutput($sformatf("v%0d_count", v), 32'(fifoCount), 1);
      checkOutput($sformatf("v%0d_active_c1", v), 32'(hskActive), 0);
      for (int k = 0; k < FRAME_CYCLES; k++) begin
        tick();
        checkOutput($sformatf("v%0d_tx_c%0d", v, k), 32'(hskTx), 32'(vecs[v].frame[k / CPB]));
        checkOutput($sformatf("v%0d_active_c%0d", v, k), 32'(hskActive), 1);
      end
      tick();
      checkOutput($sformatf("v%0d_active_end", v), 32'(hskActive), 0);
      checkOutput($sformatf("v%0d_tx_end", v), 32'(hskTx), 1);
      checkOutput($sformatf("v%0d_count_end", v), 32'(fifoCount), 0);
      repeat (3) tick();
    end

    // Three back-to-back bytes: contiguous framing, peak occupancy 2
    rxQ.delete();
    monEn  = 1'b1;
    sTdata = 8'h5A;
    sTvalid = 1'b1;
    tick();
    checkOutput("b2b_count_e0", 32'(fifoCount), 1);
    sTdata = 8'hC3;
    tick();
    checkOutput("b2b_active_start", 32'(hskActive), 1);
    peak = fifoCount;
    activeCycles = 1;
    sTdata = 8'h0F;
    tick();
    sTvalid = 1'b0;
    guard = 0;
    while (hskActive && guard < 300) begin
      if (fifoCount > CW'(peak)) peak = fifoCount;
      activeCycles++;
      tick();
      guard++;
    end
    checkOutput("b2b_active_cycles", activeCycles, 3 * FRAME_CYCLES);
    checkOutput("b2b_count_peak", peak, 2);
    checkOutput("b2b_rx_size", rxQ.size(), 3);
    if (rxQ.size() == 3) begin
      checkOutput("b2b_rx0", 32'(rxQ[0]), 32'h5A);
      checkOutput("b2b_rx1", 32'(rxQ[1]), 32'hC3);
      checkOutput("b2b_rx2", 32'(rxQ[2]), 32'h0F);
    end
    repeat (3) tick();

    // Overfill with valid held: backpressure, order preserved
    rxQ.delete();
    sent        = 0;
    peak        = 0;
    guard       = 0;
    sawNotReady = 1'b0;
    sTdata      = 8'h30;
    sTvalid     = 1'b1;
    while (sent < DEPTH + 2 && guard < 2000) begin
      hs = sTready;
      tick();
      guard++;
      if (hs) begin
        sent++;
        sTdata = 8'(8'h30 + sent);
      end else begin
        sawNotReady = 1'b1;
      end
      if (fifoCount > CW'(peak)) peak = fifoCount;
    end
    sTvalid = 1'b0;
    checkOutput("full_sent", sent, DEPTH + 2);
    checkOutput("full_backpressure", 32'(sawNotReady), 1);
    checkOutput("full_peak", peak, DEPTH);
    guard = 0;
    while ((rxQ.size() < DEPTH + 2 || hskActive) && guard < (DEPTH + 4) * FRAME_CYCLES) begin
      tick();
      guard++;
    end
    checkOutput("full_rx_size", rxQ.size(), DEPTH + 2);
    for (int i = 0; i < DEPTH + 2 && i < rxQ.size(); i++) begin
      checkOutput($sformatf("full_rx%0d", i), 32'(rxQ[i]), 32'(8'h30 + i));
    end
    checkOutput("full_count_end", 32'(fifoCount), 0);
    monEn = 1'b0;
    repeat (3) tick();

    // Null window midway through frame 2 of 4
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    repeat (58) tick();
    checkOutput("null_pre_active", 32'(hskActive), 1);
    checkOutput("null_pre_count", 32'(fifoCount), 2);
    wdNull = 1'b1;
    tick();
    checkOutput("null_tx_low", 32'(hskTx), 0);
    checkOutput("null_active_low", 32'(hskActive), 0);
    checkOutput("null_count_flushed", 32'(fifoCount), 0);
    sawActivity = 1'b0;
    for (int i = 1; i < 36; i++) begin
      tick();
      if (hskTx !== 1'b0) sawActivity = 1'b1;
    end
    checkOutput("null_held_low", 32'(sawActivity), 0);
    wdNull = 1'b0;
    tick();
    checkOutput("null_tx_release", 32'(hskTx), 1);
    sawActivity = 1'b0;
    repeat (200) begin
      tick();
      if (hskTx !== 1'b1 || hskActive !== 1'b0) sawActivity = 1'b1;
    end
    checkOutput("null_no_resend", 32'(sawActivity), 0);
    checkOutput("null_count_end", 32'(fifoCount), 0);
`ifdef HSK_UART_TX_STATS_EN
    checkOutput("stats_tx_bytes", 32'(txBytes), 27);
`endif

    // Asynchronous reset during DATA
    applyStimulus(8'h96);
    applyStimulus(8'h69);
    applyStimulus(8'hE7);
    repeat (9) tick();
    checkOutput("arst_pre_active", 32'(hskActive), 1);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("arst_tx", 32'(hskTx), 1);
    checkOutput("arst_active", 32'(hskActive), 0);
    checkOutput("arst_count", 32'(fifoCount), 0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    sawActivity = 1'b0;
    repeat (60) begin
      tick();
      if (hskTx !== 1'b1 || hskActive !== 1'b0 || fifoCount !== '0) sawActivity = 1'b1;
    end
    checkOutput("arst_idle_after", 32'(sawActivity), 0);
    checkOutput("arst_ready_after", 32'(sTready), 1);

    // Watchdog trigger: bytes accepted and discarded, line stays idle
    wdTrigger = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      sTdata  = 8'(8'hA0 + i);
      sTvalid = 1'b1;
      checkOutput($sformatf("trig_ready%0d", i), 32'(sTready), 1);
      tick();
    end
    sTvalid = 1'b0;
    sawActivity = 1'b0;
    repeat (60) begin
      tick();
      if (hskTx !== 1'b1 || hskActive !== 1'b0 || fifoCount !== '0) sawActivity = 1'b1;
    end
    checkOutput("trig_line_idle", 32'(sawActivity), 0);
`ifdef HSK_UART_TX_STATS_EN
    checkOutput("stats_drop_bytes", 32'(dropBytes), 5);
    checkOutput("stats_tx_bytes_trig", 32'(txBytes), 0);
`endif
    wdTrigger = 1'b0;
    sawActivity = 1'b0;
    repeat (20) begin
      tick();
      if (hskTx !== 1'b1 || hskActive !== 1'b0) sawActivity = 1'b1;
    end
    checkOutput("trig_release_idle", 32'(sawActivity), 0);
    checkOutput("trig_release_ready", 32'(sTready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
